rvc_asap_fetch: RTL and testbench
=================================

RVC_ASAP_FETCH -- requirements
Module: rvc_asap_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named Clock and Rst.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter FIFO_DEPTH, default 4: prefetch buffer entries; power of 2, minimum 2.
REQ-004 Parameter MAX_OUTSTANDING, default 2: maximum issued-but-unanswered I_MEM requests; minimum 1, maximum FIFO_DEPTH.
REQ-005 Clock  in  1  rising-edge clock.
REQ-006 Rst  in  1  asynchronous active-high reset.
REQ-007 ImemReqValid  out  1  fetch request valid.
REQ-008 ImemReqReady  in  1  I_MEM accepts the request.
REQ-009 ImemReqAddr  out  32  fetch address, word aligned.
REQ-010 ImemRspValid  in  1  read data valid; responses return in request order, at most one per cycle, never back-pressured.
REQ-011 ImemRspData  in  32  instruction word.
REQ-012 Redirect  in  1  branch/jump/exception redirect from execute.
REQ-013 RedirectPc  in  32  new fetch address.
REQ-014 InstValid  out  1  Instruction/InstPc valid toward decode.
REQ-015 InstReady  in  1  decode consumes the instruction.
REQ-016 Instruction  out  32  oldest buffered instruction.
REQ-017 InstPc  out  32  PC of Instruction.

Function
REQ-018 A request handshake SHALL be ImemReqValid && ImemReqReady in the same cycle; ImemReqAddr SHALL hold the FetchPc register, and FetchPc SHALL advance by 4 (mod 2^32) on each handshake.
REQ-019 ImemReqValid SHALL be 1 iff !Redirect && Outstanding < MAX_OUTSTANDING && (Outstanding + FifoCount) < FIFO_DEPTH && state != DRAIN-blocked (see REQ-024); once asserted it SHALL stay asserted with a stable address until handshake or Redirect.
REQ-020 Outstanding SHALL increment on a request handshake, decrement on an accepted response, and remain unchanged when both occur in the same cycle.
REQ-021 Each non-dropped response SHALL push {ImemRspData, RspPc} into the FIFO; RspPc SHALL advance by 4 per push; the credit rule of REQ-019 guarantees no push to a full FIFO.
REQ-022 InstValid SHALL equal FIFO not-empty; a pop SHALL occur on InstValid && InstReady; simultaneous push and pop SHALL leave FifoCount unchanged; Instruction/InstPc SHALL be stable while InstValid && !InstReady.
REQ-023 Response-to-InstValid latency SHALL be 1 cycle (FIFO registered, no bypass).
REQ-024 State machine: RUN (normal fetch); DRAIN (DropCount > 0, discarding stale responses, requests permitted to the new address); transitions RUN->DRAIN on Redirect with nonzero in-flight count, DRAIN->RUN when DropCount reaches 0; Redirect in DRAIN SHALL reload DropCount.
REQ-025 On Redirect: FIFO SHALL flush (empty next cycle, any same-cycle pop ignored); FetchPc and RspPc SHALL load {RedirectPc[31:2],2'b00}; DropCount SHALL load Outstanding minus 1 if a response arrives that cycle, else Outstanding; a response in the redirect cycle SHALL be discarded; no request SHALL issue that cycle.
REQ-026 In DRAIN each response SHALL decrement DropCount and SHALL NOT be pushed; a response while DropCount = 0 SHALL be pushed normally.
REQ-027 Responses SHALL count toward Outstanding regardless of being dropped.

Reset
REQ-028 Asserting Rst SHALL immediately and asynchronously set FetchPc = RspPc = RESET_PC, Outstanding = DropCount = FifoCount = 0, state RUN; ImemReqValid = 0 and InstValid = 0 while Rst is high.
REQ-029 Reset mid-operation SHALL discard all buffered and in-flight data; I_MEM SHALL be reset concurrently so no stale response returns.
REQ-030 The first request SHALL be presented in the first cycle after Rst deasserts.

Verification
REQ-031 Reset release, ImemReqReady = 1, 1-cycle memory, InstReady = 1 -> addresses 0,4,8,... issued back-to-back; InstPc = 0 appears 2 cycles after the first handshake.
REQ-032 InstReady = 0 with defaults -> exactly 4 instructions buffered, ImemReqValid deasserts, no overflow; InstReady = 1 -> PCs 0,4,8,12 drained in order.
REQ-033 Redirect to 32'h0000_0103 with 2 outstanding -> next ImemReqAddr = 32'h0000_0100, 2 responses dropped, first InstPc = 32'h100.
REQ-034 Redirect in the same cycle as a response and as a pop -> response discarded, FIFO empty next cycle, DropCount = Outstanding - 1.
REQ-035 Second Redirect during DRAIN -> only instructions from the second target reach decode.
REQ-036 Rst asserted with full FIFO and Outstanding = 2 -> InstValid and ImemReqValid fall without a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rvc_asap_fetch.sv
// ---------------------------------------------------------------------------
// rvc_asap_fetch -- instruction fetch unit with a registered prefetch FIFO.
//
// Issues word-aligned fetch requests to I_MEM, buffers in-order responses
// in a FIFO together with their PC, and presents the oldest instruction to
// decode. A redirect flushes the FIFO, restarts fetch at the new target and
// discards every response still in flight for the old path.
//
// Ports:
//   Clock          in   rising-edge clock
//   Rst            in   asynchronous active-high reset
//   ImemReqValid   out  fetch request valid
//   ImemReqReady   in   I_MEM accepts the request
//   ImemReqAddr    out  fetch address (word aligned)
//   ImemRspValid   in   read data valid (in order, never back-pressured)
//   ImemRspData    in   instruction word
//   Redirect       in   branch/jump/exception redirect
//   RedirectPc     in   new fetch address
//   InstValid      out  Instruction/InstPc valid toward decode
//   InstReady      in   decode consumes the instruction
//   Instruction    out  oldest buffered instruction
//   InstPc         out  PC of Instruction
// ---------------------------------------------------------------------------
module rvc_asap_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        Clock,
    input  logic        Rst,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemReqAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstPc
);

    // Pointer width, and counter width able to hold the value FIFO_DEPTH.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] DEPTH_C   = SW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE_C = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetchState_t;

    fetchState_t   state_r;
    fetchState_t   stateNext_s;

    logic [31:0]   fetchPc_r;
    logic [31:0]   rspPc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] dropCount_r;
    logic [CW-1:0] fifoCount_r;
    logic [PW-1:0] wrPtr_r;
    logic [PW-1:0] rdPtr_r;
    logic [31:0]   fifoData_r [FIFO_DEPTH];
    logic [31:0]   fifoPc_r   [FIFO_DEPTH];

    logic          reqValid_s;
    logic          reqFire_s;
    logic          push_s;
    logic          pop_s;
    logic          instValid_s;
    logic [SW-1:0] credit_s;
    logic [31:0]   redirectAligned_s;
    logic [31:0]   fetchPcNext_s;
    logic [31:0]   rspPcNext_s;
    logic [CW-1:0] outstandingNext_s;
    logic [CW-1:0] dropCountNext_s;
    logic [CW-1:0] fifoCountNext_s;

    // The two low redirect bits are discarded by word alignment.
    logic          unusedRedirectLow_s;
    assign unusedRedirectLow_s = ^RedirectPc[1:0];

    assign redirectAligned_s = {RedirectPc[31:2], 2'b00};
    assign instValid_s       = (fifoCount_r != ZERO_C);

    assign ImemReqValid = reqValid_s;
    assign ImemReqAddr  = fetchPc_r;
    assign InstValid    = instValid_s;
    assign Instruction  = fifoData_r[rdPtr_r];
    assign InstPc       = fifoPc_r[rdPtr_r];

    // Request credit and handshake/push/pop qualification.
    always_comb begin
        reqValid_s = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        // In-flight requests also reserve a FIFO slot, so a returning
        // response can never find the FIFO full. Dropped responses release
        // their slot without being pushed, which only loosens the limit.
        credit_s   = {1'b0, outstanding_r} + {1'b0, fifoCount_r};
        if (!Rst && !Redirect && (outstanding_r < MAX_OUT_C) && (credit_s < DEPTH_C)) begin
            reqValid_s = 1'b1;
        end else begin
            reqValid_s = 1'b0;
        end
        reqFire_s = reqValid_s && ImemReqReady;
        // A response in the redirect cycle belongs to the old path.
        if (ImemRspValid && !Redirect && (state_r == ST_RUN)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        // A pop coinciding with a redirect is meaningless: the FIFO flushes.
        if (instValid_s && InstReady && !Redirect) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next values of the PCs and of the in-flight / drop / fill counters.
    always_comb begin
        fetchPcNext_s     = fetchPc_r;
        rspPcNext_s       = rspPc_r;
        outstandingNext_s = outstanding_r;
        dropCountNext_s   = dropCount_r;
        fifoCountNext_s   = fifoCount_r;

        if (Redirect) begin
            fetchPcNext_s = redirectAligned_s;
            rspPcNext_s   = redirectAligned_s;
        end else begin
            if (reqFire_s) begin
                fetchPcNext_s = fetchPc_r + 32'd4;
            end else begin
                fetchPcNext_s = fetchPc_r;
            end
            if (push_s) begin
                rspPcNext_s = rspPc_r + 32'd4;
            end else begin
                rspPcNext_s = rspPc_r;
            end
        end

        // Every response retires one in-flight request, dropped or not.
        case ({reqFire_s, ImemRspValid})
            2'b10:   outstandingNext_s = outstanding_r + ONE_C;
            2'b01:   outstandingNext_s = outstanding_r - ONE_C;
            default: outstandingNext_s = outstanding_r;
        endcase

        // On redirect, everything still in flight after this cycle is stale.
        if (Redirect) begin
            if (ImemRspValid) begin
                dropCountNext_s = outstanding_r - ONE_C;
            end else begin
                dropCountNext_s = outstanding_r;
            end
        end else if (ImemRspValid && (dropCount_r != ZERO_C)) begin
            dropCountNext_s = dropCount_r - ONE_C;
        end else begin
            dropCountNext_s = dropCount_r;
        end

        if (Redirect) begin
            fifoCountNext_s = ZERO_C;
        end else begin
            case ({push_s, pop_s})
                2'b10:   fifoCountNext_s = fifoCount_r + ONE_C;
                2'b01:   fifoCountNext_s = fifoCount_r - ONE_C;
                default: fifoCountNext_s = fifoCount_r;
            endcase
        end
    end

    // RUN/DRAIN next state: DRAIN while stale responses remain to discard.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (Redirect && (dropCountNext_s != ZERO_C)) begin
                    stateNext_s = ST_DRAIN;
                end else begin
                    stateNext_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (dropCountNext_s == ZERO_C) begin
                    stateNext_s = ST_RUN;
                end else begin
                    stateNext_s = ST_DRAIN;
                end
            end
            default: stateNext_s = ST_RUN;
        endcase
    end

    // Control state registers.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_r       <= ST_RUN;
            fetchPc_r     <= RESET_PC;
            rspPc_r       <= RESET_PC;
            outstanding_r <= ZERO_C;
            dropCount_r   <= ZERO_C;
            fifoCount_r   <= ZERO_C;
        end else begin
            state_r       <= stateNext_s;
            fetchPc_r     <= fetchPcNext_s;
            rspPc_r       <= rspPcNext_s;
            outstanding_r <= outstandingNext_s;
            dropCount_r   <= dropCountNext_s;
            fifoCount_r   <= fifoCountNext_s;
        end
    end

    // FIFO pointers and storage; a redirect flushes by rewinding both pointers.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoData_r[i] <= 32'h0000_0000;
                fifoPc_r[i]   <= 32'h0000_0000;
            end
        end else if (Redirect) begin
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                fifoData_r[wrPtr_r] <= ImemRspData;
                fifoPc_r[wrPtr_r]   <= rspPc_r;
                wrPtr_r             <= wrPtr_r + PTR_ONE_C;
            end else begin
                wrPtr_r <= wrPtr_r;
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE_C;
            end else begin
                rdPtr_r <= rdPtr_r;
            end
        end
    end

endmodule

// File: tb/tb_rvc_asap_fetch.sv
// ---------------------------------------------------------------------------
// tb_rvc_asap_fetch -- randomized self-checking bench for rvc_asap_fetch.
//
// An in-order I_MEM model with random latency answers requests. A reference
// model tracks the fetch path as "epochs": each redirect starts a new epoch,
// requests are tagged with the epoch they were issued in, and only responses
// of the current epoch (not arriving in a redirect cycle) reach the expected
// decode queue. Outputs are checked every cycle, #1 after the falling edge.
// ---------------------------------------------------------------------------
module tb_rvc_asap_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;

    logic        Clock;
    logic        Rst;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [31:0] ImemReqAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic        Redirect;
    logic [31:0] RedirectPc;
    logic        InstValid;
    logic        InstReady;
    logic [31:0] Instruction;
    logic [31:0] InstPc;

    rvc_asap_fetch #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .Clock        (Clock),
        .Rst          (Rst),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemReqAddr  (ImemReqAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .Redirect     (Redirect),
        .RedirectPc   (RedirectPc),
        .InstValid    (InstValid),
        .InstReady    (InstReady),
        .Instruction  (Instruction),
        .InstPc       (InstPc)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total;
    int bad;

    // Reference model state.
    logic [31:0] pendAddr[$];
    int          pendEpoch[$];
    int          pendDue[$];
    logic [31:0] qPc[$];
    logic [31:0] qData[$];
    logic [31:0] mFetchPc;
    int          epoch;
    int          cyc;
    int          lastDue;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        pendAddr.delete();
        pendEpoch.delete();
        pendDue.delete();
        qPc.delete();
        qData.delete();
        mFetchPc = RESET_PC;
        lastDue  = 0;
    endtask

    task automatic runCycles(input int n, input int pRed, input int pRdy,
                             input int pInst, input int maxLat);
        logic rspNow;
        logic expReq;
        logic doPop;
        logic hs;
        int   lat;
        int   due;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            Redirect     = ($urandom_range(99) < pRed);
            RedirectPc   = ($urandom_range(3) == 0) ? 32'h0000_0103 : $urandom();
            ImemReqReady = ($urandom_range(99) < pRdy);
            InstReady    = ($urandom_range(99) < pInst);
            rspNow       = (pendAddr.size() > 0) && (pendDue[0] <= cyc);
            ImemRspValid = rspNow;
            ImemRspData  = rspNow ? memData(pendAddr[0]) : $urandom();
            #1;
            expReq = !Redirect && (pendAddr.size() < MAXO) &&
                     ((pendAddr.size() + qPc.size()) < DEPTH);
            checkVal("reqValid", {31'b0, ImemReqValid}, {31'b0, expReq});
            if (expReq) checkVal("reqAddr", ImemReqAddr, mFetchPc);
            checkVal("instValid", {31'b0, InstValid}, {31'b0, (qPc.size() != 0)});
            if (qPc.size() != 0) begin
                checkVal("instPc", InstPc, qPc[0]);
                checkVal("instData", Instruction, qData[0]);
            end
            // Advance the model to the state after the coming rising edge.
            hs    = expReq && ImemReqReady;
            doPop = (qPc.size() != 0) && InstReady && !Redirect;
            if (rspNow) begin
                if (!Redirect && (pendEpoch[0] == epoch)) begin
                    qPc.push_back(pendAddr[0]);
                    qData.push_back(memData(pendAddr[0]));
                end
                void'(pendAddr.pop_front());
                void'(pendEpoch.pop_front());
                void'(pendDue.pop_front());
            end
            if (doPop) begin
                void'(qPc.pop_front());
                void'(qData.pop_front());
            end
            if (hs) begin
                lat = $urandom_range(maxLat, 1);
                due = cyc + lat;
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                pendAddr.push_back(mFetchPc);
                pendEpoch.push_back(epoch);
                pendDue.push_back(due);
                mFetchPc = mFetchPc + 32'd4;
            end
            if (Redirect) begin
                qPc.delete();
                qData.delete();
                epoch++;
                mFetchPc = {RedirectPc[31:2], 2'b00};
            end
            cyc++;
        end
    endtask

    // Reset asserted between clock edges; outputs must drop with no edge.
    task automatic asyncReset();
        @(negedge Clock);
        Redirect     = 1'b0;
        ImemReqReady = 1'b0;
        InstReady    = 1'b0;
        ImemRspValid = 1'b0;
        #1;
        checkVal("preRstInstValid", {31'b0, InstValid}, {31'b0, (qPc.size() != 0)});
        #1;
        Rst = 1'b1;
        #1;
        checkVal("asyncReqValid", {31'b0, ImemReqValid}, 32'd0);
        checkVal("asyncInstValid", {31'b0, InstValid}, 32'd0);
        @(posedge Clock);
        #1;
        Rst = 1'b0;
        modelReset();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        epoch        = 0;
        cyc          = 0;
        Rst          = 1'b1;
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b0;
        ImemRspData  = 32'h0000_0000;
        Redirect     = 1'b0;
        RedirectPc   = 32'h0000_0000;
        InstReady    = 1'b0;
        modelReset();
        #12;
        checkVal("rstReqValid", {31'b0, ImemReqValid}, 32'd0);
        checkVal("rstInstValid", {31'b0, InstValid}, 32'd0);
        @(posedge Clock);
        #1;
        Rst = 1'b0;

        // Decode stalled: FIFO fills to depth and requests stop; then drain.
        runCycles(12, 0, 100, 0, 1);
        runCycles(10, 0, 100, 100, 1);

        // Restart from reset with a 1-cycle memory and decode always ready.
        asyncReset();
        runCycles(20, 0, 100, 100, 1);

        // Fill the FIFO, then reset mid-operation.
        runCycles(8, 0, 100, 0, 1);
        asyncReset();

        // Randomized traffic, including redirects during DRAIN.
        runCycles(1500, 5, 70, 70, 3);
        runCycles(1500, 25, 80, 50, 2);
        runCycles(500, 10, 100, 100, 1);
        asyncReset();
        runCycles(500, 15, 60, 60, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
